// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : IF stage with one outstanding imem request, ID hold buffer and
//            delayed-branch redirect handling.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic [31:0] branch_addr,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        id_valid
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [31:0] pc_f;
    logic        redir_pend;
    logic [31:0] redir_tgt;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic        redirect;
    logic [31:0] redirect_target;
    logic        deliver_wait;
    logic        deliver_hold;
    logic        deliver;
    logic        capture_hold;
    logic [31:0] deliver_pc;
    logic [31:0] deliver_instr;

    assign redirect        = id_valid & (jump | jump_branch);
    assign redirect_target = jump ? jump_target : branch_addr;
    assign deliver_wait    = (state == S_WAIT) & imem_rvalid & ~stall;
    assign deliver_hold    = (state == S_HOLD) & ~stall;
    assign deliver         = deliver_wait | deliver_hold;
    assign capture_hold    = (state == S_WAIT) & imem_rvalid & stall;
    assign deliver_pc      = deliver_hold ? hold_pc    : pc_f;
    assign deliver_instr   = deliver_hold ? hold_instr : imem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH: if (imem_ready)  state_nx = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_nx = stall ? S_HOLD : S_FETCH;
            S_HOLD:  if (!stall)      state_nx = S_FETCH;
            default:                  state_nx = S_FETCH;
        endcase
    end

    // imem_req depends on state only, so imem_rvalid never reaches it combinationally
    always_comb begin
        imem_req  = (state == S_FETCH) & ~rst;
        imem_addr = pc_f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f       <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'd0;
            hold_pc    <= 32'd0;
            hold_instr <= 32'd0;
            pc_id      <= RESET_PC;
            instr_id   <= 32'd0;
            id_valid   <= 1'b0;
        end else begin
            if (capture_hold) begin
                hold_pc    <= pc_f;
                hold_instr <= imem_rdata;
            end
            if (deliver) begin
                pc_id      <= deliver_pc;
                instr_id   <= deliver_instr;
                id_valid   <= 1'b1;
                redir_pend <= 1'b0;
                if (redirect) begin
                    pc_f <= redirect_target;
                end else if (redir_pend) begin
                    pc_f <= redir_tgt;
                end else begin
                    pc_f <= deliver_pc + 32'd4;
                end
            end else if (!stall) begin
                // Bubble edge: a redirect seen now waits until the delay slot is delivered
                instr_id <= 32'd0;
                id_valid <= 1'b0;
                if (redirect) begin
                    redir_pend <= 1'b1;
                    redir_tgt  <= redirect_target;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch against a program-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_branch;
    logic [31:0] branch_addr;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        id_valid;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_branch (jump_branch),
        .branch_addr (branch_addr),
        .jump        (jump),
        .jump_target (jump_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .id_valid    (id_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Program/model state
    int          mode;
    int          stall_pct, ready_pct, spur_pct, lat_max;
    logic [31:0] fetch_addr;
    logic [31:0] pend;
    bit          pend_v;
    bit          outstanding;
    int          lat;
    logic [31:0] out_addr;
    bit          word_avail;
    logic [31:0] avail_pc;
    int          ndel;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0003;
    endfunction

    // kind: 0 none, 1 branch taken, 2 jump, 3 jump+branch together
    function automatic logic [1:0] kind_of(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h2545_F491;
        if (mode == 1) begin
            case (a)
                32'h10:  return 2'd1;
                32'h48:  return 2'd2;
                32'h104: return 2'd3;
                32'h208: return 2'd2;
                default: return 2'd0;
            endcase
        end else if (mode == 2) begin
            return (h[31:29] == 3'd0) ? ((h[28:27] == 2'd0) ? 2'd1 : h[28:27]) : 2'd0;
        end
        return 2'd0;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h2545_F491;
        if (mode == 1) begin
            case (a)
                32'h10:  return 32'h40;
                32'h48:  return 32'h100;
                32'h104: return 32'h200;
                default: return 32'hFFFF_FFF8;
            endcase
        end
        return (h[26:25] == 2'd0) ? 32'hFFFF_FFF8 : {22'd0, h[9:2], 2'b00};
    endfunction

    task automatic model_reset();
        fetch_addr  = RESET_PC;
        pend_v      = 1'b0;
        pend        = 32'd0;
        outstanding = 1'b0;
        word_avail  = 1'b0;
        lat         = 0;
        ndel        = 0;
    endtask

    task automatic step();
        logic [1:0]  k;
        logic [31:0] t, ppc, pin, nxt;
        logic        pv, st, rv_real, acc;
        stall       = ($urandom_range(99) < stall_pct);
        k           = id_valid ? kind_of(pc_id) : 2'd0;
        t           = tgt_of(pc_id);
        jump_branch = k[0];
        jump        = k[1];
        jump_target = k[1] ? t : ($urandom & 32'hFFFF_FFFC);
        branch_addr = (k == 2'd1) ? t : (t ^ 32'h0000_0100);
        rv_real     = outstanding && (lat == 0);
        if (rv_real) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(out_addr);
        end else begin
            imem_rvalid = !outstanding && ($urandom_range(99) < spur_pct);
            imem_rdata  = $urandom;
        end
        imem_ready = ($urandom_range(99) < ready_pct);
        #1;
        st  = stall;
        ppc = pc_id;
        pin = instr_id;
        pv  = id_valid;
        acc = imem_req && imem_ready;
        if (rv_real) begin
            word_avail  = 1'b1;
            avail_pc    = out_addr;
            outstanding = 1'b0;
        end else if (outstanding) begin
            lat = lat - 1;
        end
        if (acc) begin
            total++;
            if (imem_addr !== fetch_addr) begin
                bad++;
                $display("FAIL fetch_addr: got %h want %h", imem_addr, fetch_addr);
            end
            if (outstanding || word_avail) begin
                bad++;
                $display("FAIL one_outstanding: request accepted while a word is still pending");
            end
            outstanding = 1'b1;
            out_addr    = fetch_addr;
            lat         = $urandom_range(lat_max);
        end
        @(posedge clk);
        #1;
        total++;
        if (st) begin
            if (id_valid !== pv || pc_id !== ppc || instr_id !== pin) begin
                bad++;
                $display("FAIL stall_hold: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h",
                         id_valid, pc_id, instr_id, pv, ppc, pin);
            end
        end else if (word_avail) begin
            if (id_valid !== 1'b1 || pc_id !== avail_pc || instr_id !== mem_word(avail_pc)) begin
                bad++;
                $display("FAIL delivery: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         id_valid, pc_id, instr_id, avail_pc, mem_word(avail_pc));
            end
            word_avail = 1'b0;
            ndel++;
            nxt    = pend_v ? pend : (avail_pc + 32'd4);
            pend_v = 1'b0;
            if (kind_of(avail_pc) != 2'd0) begin
                pend   = tgt_of(avail_pc);
                pend_v = 1'b1;
            end
            fetch_addr = nxt;
        end else begin
            if (id_valid !== 1'b0 || instr_id !== 32'd0 || pc_id !== ppc) begin
                bad++;
                $display("FAIL bubble: got v=%b pc=%h ins=%h want v=0 pc=%h ins=0",
                         id_valid, pc_id, instr_id, ppc);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0; jump = 1'b0; jump_branch = 1'b0;
        jump_target = 32'd0; branch_addr = 32'd0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || id_valid !== 1'b0 ||
            pc_id !== RESET_PC || instr_id !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b addr=%h v=%b pc=%h ins=%h want 0/%h/0/%h/0",
                     imem_req, imem_addr, id_valid, pc_id, instr_id, RESET_PC, RESET_PC);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL first_req: got req=%b want 1", imem_req);
        end
        model_reset();
    endtask

    task automatic test_zero_wait();
        mode = 0; stall_pct = 0; ready_pct = 100; spur_pct = 0; lat_max = 0;
        test_reset();
        repeat (6) step();
        total++;
        if (ndel != 3 || pc_id !== 32'h8) begin
            bad++;
            $display("FAIL zero_wait: got deliveries=%0d pc=%h want 3 / 00000008", ndel, pc_id);
        end
    endtask

    task automatic test_stall_hold();
        mode = 0; spur_pct = 0; lat_max = 0; ready_pct = 100;
        test_reset();
        stall_pct = 0;   step();
        stall_pct = 100; repeat (3) step();
        stall_pct = 0;   step();
        total++;
        if (ndel != 1 || pc_id !== RESET_PC || id_valid !== 1'b1) begin
            bad++;
            $display("FAIL held_word: got deliveries=%0d pc=%h v=%b want 1 / %h / 1",
                     ndel, pc_id, id_valid, RESET_PC);
        end
        repeat (4) step();
    endtask

    task automatic test_reset_in_wait();
        mode = 0; stall_pct = 0; ready_pct = 100; spur_pct = 0; lat_max = 2;
        test_reset();
        step();
        rst = 1'b1;
        #2;
        total++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got v=%b req=%b want 0/0", id_valid, imem_req);
        end
        rst = 1'b0;
        model_reset();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        stall = 1'b0; jump = 1'b0; jump_branch = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                bad++;
                $display("FAIL late_rvalid: got v=%b req=%b addr=%h want 0/1/%h",
                         id_valid, imem_req, imem_addr, RESET_PC);
            end
        end
        repeat (10) step();
    endtask

    task automatic test_directed_program();
        mode = 1; stall_pct = 25; ready_pct = 80; spur_pct = 20; lat_max = 3;
        test_reset();
        repeat (900) step();
        total++;
        if (ndel < 60) begin
            bad++;
            $display("FAIL progress_directed: got deliveries=%0d want >=60", ndel);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2; stall_pct = 30; ready_pct = 70; spur_pct = 20; lat_max = 2;
        test_reset();
        repeat (1500) step();
        total++;
        if (ndel < 100) begin
            bad++;
            $display("FAIL progress_random: got deliveries=%0d want >=100", ndel);
        end
    endtask

    initial begin
        test_zero_wait();
        test_stall_hold();
        test_reset_in_wait();
        test_directed_program();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
